// File: rtl/io_clk_p.sv
// Shared widths, pause thresholds and FSM state type for the programmable IO clock generator.
package io_clk_p;

  localparam int unsigned DIV_BITWIDTH   = 8;
  localparam int unsigned CYCLE_BITWIDTH = 16;
  localparam int unsigned SHORT_LENGTH   = 4;
  localparam int unsigned LONG_LENGTH    = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    RUN,
    PAUSE_PEND,
    PAUSED
  } gen_state_t;

endpackage

// File: rtl/clock_gen_pause_tracker.sv
// Pause-length counter with saturation and once-per-pause short/long pulse generation.
module clock_gen_pause_tracker #(
  parameter int unsigned CYCLE_BITWIDTH = io_clk_p::CYCLE_BITWIDTH,
  parameter int unsigned SHORT_LENGTH   = io_clk_p::SHORT_LENGTH,
  parameter int unsigned LONG_LENGTH    = io_clk_p::LONG_LENGTH
) (
  input  logic                      clk,
  input  logic                      arst_n,
  input  logic                      clk_en,
  input  logic                      enter,
  input  logic                      inc,
  input  logic                      clr,
  input  logic [CYCLE_BITWIDTH-1:0] pre_count,
  output logic [CYCLE_BITWIDTH-1:0] count,
  output logic                      sync_short,
  output logic                      sync_long,
  output logic                      pre_short,
  output logic                      pre_long
);

  localparam logic [CYCLE_BITWIDTH-1:0] SHORT_C = CYCLE_BITWIDTH'(SHORT_LENGTH);
  localparam logic [CYCLE_BITWIDTH-1:0] LONG_C  = CYCLE_BITWIDTH'(LONG_LENGTH);

  // bit order of the flag/pulse vectors: sync_short, sync_long, pre_short, pre_long
  logic [CYCLE_BITWIDTH-1:0] count_d;
  logic [CYCLE_BITWIDTH-1:0] pre_short_tgt;
  logic [CYCLE_BITWIDTH-1:0] pre_long_tgt;
  logic [3:0]                fired_q;
  logic [3:0]                fired_d;
  logic [3:0]                base;
  logic [3:0]                hit;
  logic [3:0]                pulse_q;
  logic [3:0]                pulse_d;

  // Early-warning targets; a warning distance beyond the threshold fires on pause entry.
  always_comb begin
    pre_short_tgt = (pre_count >= SHORT_C) ? '0 : SHORT_C - pre_count;
    pre_long_tgt  = (pre_count >= LONG_C)  ? '0 : LONG_C - pre_count;
  end

  // Next count, threshold hits and per-pause fired flags.
  always_comb begin
    count_d = count;
    fired_d = fired_q;
    pulse_d = '0;
    base    = fired_q;
    hit     = '0;
    if (clr) begin
      count_d = '0;
      fired_d = '0;
    end else if (enter || inc) begin
      if (enter) begin
        count_d = '0;
        base    = '0;
      end else if (count != LONG_C) begin
        count_d = count + CYCLE_BITWIDTH'(1);
      end
      hit[0]  = (count_d == SHORT_C);
      hit[1]  = (count_d == LONG_C);
      hit[2]  = (count_d == pre_short_tgt);
      hit[3]  = (count_d == pre_long_tgt);
      pulse_d = hit & ~base;
      fired_d = base | hit;
    end
  end

  // Counter, flag and pulse registers.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      count   <= '0;
      fired_q <= '0;
      pulse_q <= '0;
    end else if (clk_en) begin
      count   <= count_d;
      fired_q <= fired_d;
      pulse_q <= pulse_d;
    end
  end

  assign sync_short = pulse_q[0];
  assign sync_long  = pulse_q[1];
  assign pre_short  = pulse_q[2];
  assign pre_long   = pulse_q[3];

endmodule

// File: rtl/clock_generation_prog.sv
// Programmable, pausable output clock divider with pause-length tracking.
module clock_generation_prog #(
  parameter int unsigned DIV_BITWIDTH   = io_clk_p::DIV_BITWIDTH,
  parameter int unsigned CYCLE_BITWIDTH = io_clk_p::CYCLE_BITWIDTH,
  parameter int unsigned SHORT_LENGTH   = io_clk_p::SHORT_LENGTH,
  parameter int unsigned LONG_LENGTH    = io_clk_p::LONG_LENGTH
) (
  input  logic                      clk,
  input  logic                      arst_n,
  input  logic                      clk_en,
  input  logic                      generation_enable_i,
  input  logic [DIV_BITWIDTH-1:0]   half_period_i,
  input  logic                      pause_enable_i,
  input  logic [CYCLE_BITWIDTH-1:0] preemptive_cycle_count_i,
  output logic                      sync_short_pause_o,
  output logic                      sync_long_pause_o,
  output logic                      pre_short_pause_o,
  output logic                      pre_long_pause_o,
  output logic [CYCLE_BITWIDTH-1:0] pause_count_o,
  output logic                      paused_o,
  output logic                      clk_lock_o,
  output logic                      clk_o
);

  import io_clk_p::*;

  gen_state_t                state;
  gen_state_t                state_d;
  logic [DIV_BITWIDTH-1:0]   phase_q;
  logic [DIV_BITWIDTH-1:0]   phase_d;
  logic [DIV_BITWIDTH-1:0]   phase_nxt;
  logic [DIV_BITWIDTH-1:0]   half_q;
  logic [DIV_BITWIDTH-1:0]   half_d;
  logic [CYCLE_BITWIDTH-1:0] pre_q;
  logic [CYCLE_BITWIDTH-1:0] pre_d;
  logic                      vclk_q;
  logic                      vclk_d;
  logic                      clk_d;
  logic                      lock_d;
  logic                      paused_d;
  logic                      wrap;
  logic                      enter;
  logic                      inc;
  logic                      clr;

  // Half-period boundary detection; vclk keeps the virtual clock level running while parked.
  always_comb begin
    wrap      = (phase_q == (half_q - DIV_BITWIDTH'(1)));
    phase_nxt = wrap ? '0 : phase_q + DIV_BITWIDTH'(1);
  end

  // Next-state and registered-output values; disable overrides every state.
  always_comb begin
    state_d  = state;
    phase_d  = phase_q;
    half_d   = half_q;
    pre_d    = pre_q;
    vclk_d   = vclk_q;
    clk_d    = clk_o;
    lock_d   = clk_lock_o;
    paused_d = paused_o;
    enter    = 1'b0;
    inc      = 1'b0;
    clr      = 1'b0;
    if (!generation_enable_i) begin
      state_d  = IDLE;
      phase_d  = '0;
      vclk_d   = 1'b1;
      clk_d    = 1'b1;
      lock_d   = 1'b0;
      paused_d = 1'b0;
      clr      = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          half_d  = (half_period_i == '0) ? DIV_BITWIDTH'(1) : half_period_i;
          pre_d   = preemptive_cycle_count_i;
          phase_d = '0;
          state_d = START;
        end
        START: begin
          phase_d = '0;
          vclk_d  = 1'b1;
          clk_d   = 1'b1;
          lock_d  = 1'b1;
          state_d = RUN;
        end
        RUN: begin
          phase_d = phase_nxt;
          if (wrap) begin
            vclk_d = ~vclk_q;
            clk_d  = ~vclk_q;
          end
          if (pause_enable_i) state_d = PAUSE_PEND;
        end
        PAUSE_PEND: begin
          phase_d = phase_nxt;
          if (wrap) begin
            vclk_d = ~vclk_q;
            clk_d  = ~vclk_q;
          end
          if (!pause_enable_i) begin
            state_d = RUN;
          end else if (wrap && !vclk_q) begin
            state_d  = PAUSED;
            paused_d = 1'b1;
            enter    = 1'b1;
          end
        end
        PAUSED: begin
          phase_d = phase_nxt;
          if (wrap) vclk_d = ~vclk_q;
          if (wrap && vclk_q) begin
            if (!pause_enable_i) begin
              state_d  = RUN;
              clk_d    = 1'b0;
              paused_d = 1'b0;
              clr      = 1'b1;
            end else begin
              inc = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state <= IDLE;
    else if (clk_en) state <= state_d;
  end

  // Phase counter, latched settings and output registers.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      phase_q    <= '0;
      half_q     <= DIV_BITWIDTH'(1);
      pre_q      <= '0;
      vclk_q     <= 1'b1;
      clk_o      <= 1'b1;
      clk_lock_o <= 1'b0;
      paused_o   <= 1'b0;
    end else if (clk_en) begin
      phase_q    <= phase_d;
      half_q     <= half_d;
      pre_q      <= pre_d;
      vclk_q     <= vclk_d;
      clk_o      <= clk_d;
      clk_lock_o <= lock_d;
      paused_o   <= paused_d;
    end
  end

  clock_gen_pause_tracker #(
    .CYCLE_BITWIDTH (CYCLE_BITWIDTH),
    .SHORT_LENGTH   (SHORT_LENGTH),
    .LONG_LENGTH    (LONG_LENGTH)
  ) u_tracker (
    .clk        (clk),
    .arst_n     (arst_n),
    .clk_en     (clk_en),
    .enter      (enter),
    .inc        (inc),
    .clr        (clr),
    .pre_count  (pre_q),
    .count      (pause_count_o),
    .sync_short (sync_short_pause_o),
    .sync_long  (sync_long_pause_o),
    .pre_short  (pre_short_pause_o),
    .pre_long   (pre_long_pause_o)
  );

endmodule

// File: tb/tb_clock_generation_prog.sv
// Directed bench for clock_generation_prog with hand-computed expectations.
module tb_clock_generation_prog;

  logic        clk;
  logic        arst_n;
  logic        clk_en;
  logic        gen_en;
  logic [7:0]  half_period;
  logic        pause_en;
  logic [15:0] pre_count;
  logic        sync_short;
  logic        sync_long;
  logic        pre_short;
  logic        pre_long;
  logic [15:0] pause_count;
  logic        paused;
  logic        clk_lock;
  logic        clk_out;

  int total = 0;
  int bad   = 0;

  clock_generation_prog dut (
    .clk                      (clk),
    .arst_n                   (arst_n),
    .clk_en                   (clk_en),
    .generation_enable_i      (gen_en),
    .half_period_i            (half_period),
    .pause_enable_i           (pause_en),
    .preemptive_cycle_count_i (pre_count),
    .sync_short_pause_o       (sync_short),
    .sync_long_pause_o        (sync_long),
    .pre_short_pause_o        (pre_short),
    .pre_long_pause_o         (pre_long),
    .pause_count_o            (pause_count),
    .paused_o                 (paused),
    .clk_lock_o               (clk_lock),
    .clk_o                    (clk_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives the enable with the given settings; returns just after the START edge.
  task automatic start_gen(input logic [7:0] h, input logic [15:0] p, input logic pa);
    half_period = h;
    pre_count   = p;
    pause_en    = pa;
    gen_en      = 1'b1;
    tick(1);
  endtask

  task automatic stop_gen();
    gen_en   = 1'b0;
    pause_en = 1'b0;
    tick(1);
  endtask

  initial begin
    arst_n      = 1'b0;
    clk_en      = 1'b1;
    gen_en      = 1'b0;
    half_period = 8'd0;
    pause_en    = 1'b0;
    pre_count   = 16'd0;
    tick(2);
    chk("rst_clk", 32'(clk_out), 1);
    chk("rst_lock", 32'(clk_lock), 0);
    chk("rst_paused", 32'(paused), 0);
    chk("rst_count", 32'(pause_count), 0);
    chk("rst_pulses", 32'({sync_short, sync_long, pre_short, pre_long}), 0);
    arst_n = 1'b1;
    tick(1);

    // H=3: lock two cycles after enable, 6-cycle period, first edge falling
    start_gen(8'd3, 16'd0, 1'b0);
    chk("h3_lock_start", 32'(clk_lock), 0);
    chk("h3_clk_start", 32'(clk_out), 1);
    tick(1);
    chk("h3_lock_run", 32'(clk_lock), 1);
    chk("h3_clk_g2", 32'(clk_out), 1);
    tick(2);
    chk("h3_clk_g4", 32'(clk_out), 1);
    tick(1);
    chk("h3_clk_g5", 32'(clk_out), 0);
    tick(2);
    chk("h3_clk_g7", 32'(clk_out), 0);
    tick(1);
    chk("h3_clk_g8", 32'(clk_out), 1);
    tick(3);
    chk("h3_clk_g11", 32'(clk_out), 0);
    stop_gen();
    chk("dis_run_clk", 32'(clk_out), 1);
    chk("dis_run_lock", 32'(clk_lock), 0);
    chk("dis_run_paused", 32'(paused), 0);

    // H=0 behaves as H=1; clk_en gaps stretch the period
    start_gen(8'd0, 16'd0, 1'b0);
    tick(1);
    chk("h0_clk_g2", 32'(clk_out), 1);
    tick(1);
    chk("h0_clk_g3", 32'(clk_out), 0);
    tick(1);
    chk("h0_clk_g4", 32'(clk_out), 1);
    clk_en = 1'b0;
    tick(1);
    chk("h0_hold_hi", 32'(clk_out), 1);
    clk_en = 1'b1;
    tick(1);
    chk("h0_en_lo", 32'(clk_out), 0);
    clk_en = 1'b0;
    tick(1);
    chk("h0_hold_lo", 32'(clk_out), 0);
    clk_en = 1'b1;
    tick(1);
    chk("h0_en_hi", 32'(clk_out), 1);
    stop_gen();

    // H=4, P=2, pause asserted in the low phase; full pause to saturation
    start_gen(8'd4, 16'd2, 1'b0);
    tick(5);
    chk("p_clk_g6", 32'(clk_out), 0);
    tick(1);
    pause_en = 1'b1;
    tick(2);
    chk("p_clk_g9", 32'(clk_out), 0);
    chk("p_paused_g9", 32'(paused), 0);
    tick(1);
    chk("p_clk_g10", 32'(clk_out), 1);
    chk("p_paused_g10", 32'(paused), 1);
    chk("p_count_g10", 32'(pause_count), 0);
    chk("p_pre_short_g10", 32'(pre_short), 0);
    tick(11);
    chk("p_count_g21", 32'(pause_count), 1);
    chk("p_pre_short_g21", 32'(pre_short), 0);
    tick(1);
    chk("p_count_g22", 32'(pause_count), 2);
    chk("p_pre_short_g22", 32'(pre_short), 1);
    tick(1);
    chk("p_pre_short_g23", 32'(pre_short), 0);
    tick(15);
    chk("p_count_g38", 32'(pause_count), 4);
    chk("p_sync_short_g38", 32'(sync_short), 1);
    tick(1);
    chk("p_sync_short_g39", 32'(sync_short), 0);
    tick(79);
    chk("p_count_g118", 32'(pause_count), 14);
    chk("p_pre_long_g118", 32'(pre_long), 1);
    tick(16);
    chk("p_count_g134", 32'(pause_count), 16);
    chk("p_sync_long_g134", 32'(sync_long), 1);
    chk("p_clk_g134", 32'(clk_out), 1);
    tick(8);
    chk("p_count_sat", 32'(pause_count), 16);
    chk("p_sync_long_once", 32'(sync_long), 0);
    pause_en = 1'b0;
    tick(7);
    chk("p_clk_g149", 32'(clk_out), 1);
    chk("p_paused_g149", 32'(paused), 1);
    tick(1);
    chk("p_clk_leave", 32'(clk_out), 0);
    chk("p_paused_leave", 32'(paused), 0);
    chk("p_count_leave", 32'(pause_count), 0);
    tick(4);
    chk("p_clk_g154", 32'(clk_out), 1);
    stop_gen();

    // Deassert pause at count 5; no long pulses, resume on next virtual falling boundary
    start_gen(8'd4, 16'd2, 1'b1);
    tick(9);
    chk("r_paused_g10", 32'(paused), 1);
    tick(36);
    chk("r_count_g46", 32'(pause_count), 5);
    pause_en = 1'b0;
    tick(7);
    chk("r_clk_g53", 32'(clk_out), 1);
    chk("r_count_g53", 32'(pause_count), 5);
    tick(1);
    chk("r_clk_g54", 32'(clk_out), 0);
    chk("r_count_g54", 32'(pause_count), 0);
    chk("r_paused_g54", 32'(paused), 0);
    chk("r_long_g54", 32'({sync_long, pre_long}), 0);
    tick(4);
    chk("r_clk_g58", 32'(clk_out), 1);
    stop_gen();

    // P=20: both warnings on the PAUSED entry cycle; disable suppresses the due sync pulse
    start_gen(8'd4, 16'd20, 1'b1);
    tick(9);
    chk("e_paused_g10", 32'(paused), 1);
    chk("e_pre_short_g10", 32'(pre_short), 1);
    chk("e_pre_long_g10", 32'(pre_long), 1);
    chk("e_sync_g10", 32'({sync_short, sync_long}), 0);
    tick(1);
    chk("e_pre_g11", 32'({pre_short, pre_long}), 0);
    tick(26);
    chk("e_count_g37", 32'(pause_count), 3);
    gen_en = 1'b0;
    tick(1);
    chk("e_dis_sync_short", 32'(sync_short), 0);
    chk("e_dis_count", 32'(pause_count), 0);
    chk("e_dis_paused", 32'(paused), 0);
    chk("e_dis_clk", 32'(clk_out), 1);
    chk("e_dis_lock", 32'(clk_lock), 0);
    pause_en = 1'b0;
    tick(1);

    // Asynchronous reset in the middle of a pause
    start_gen(8'd4, 16'd2, 1'b1);
    tick(19);
    chk("a_count_g20", 32'(pause_count), 1);
    arst_n = 1'b0;
    #1;
    chk("a_clk", 32'(clk_out), 1);
    chk("a_lock", 32'(clk_lock), 0);
    chk("a_paused", 32'(paused), 0);
    chk("a_count", 32'(pause_count), 0);
    gen_en   = 1'b0;
    pause_en = 1'b0;
    tick(1);
    arst_n = 1'b1;
    tick(2);
    chk("a_idle_lock", 32'(clk_lock), 0);
    chk("a_idle_clk", 32'(clk_out), 1);
    chk("a_idle_pulses", 32'({sync_short, sync_long, pre_short, pre_long}), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clock_generation_prog.md
Name: clock_generation_prog

Overview:
Programmable successor to the fixed 64-cycle-period clock generator.
- Derives an output clock from the system clock using a runtime-selectable half-period.
- Output clock idles high; pause parks it high and counts the length of the pause.
- Issues short/long pause completion pulses in two forms: on time (sync) and a programmable number of output periods early (preemptive).
- Sits between the system clock domain and an IO interface that needs a slow, pausable bit clock.

Parameters:
- DIV_BITWIDTH, 8, width of half_period_i and of the phase counter.
- CYCLE_BITWIDTH, 16, width of the pause counter and of preemptive_cycle_count_i.
- SHORT_LENGTH, 4, pause length in output periods that triggers the short pulses.
- LONG_LENGTH, 16, pause length that triggers the long pulses; also the pause-counter saturation value. Must be greater than SHORT_LENGTH.

Ports:
- clk  input  1  system clock.
- arst_n  input  1  asynchronous active-low reset.
- clk_en  input  1  qualifies every state update; registers hold when low.
- generation_enable_i  input  1  run or stop the output clock.
- half_period_i  input  DIV_BITWIDTH  system-clock cycles per output half-period; latched on the IDLE->START transition; 0 is treated as 1.
- pause_enable_i  input  1  request to park clk_o high (1) or resume (0).
- preemptive_cycle_count_i  input  CYCLE_BITWIDTH  early-warning distance, in output periods; latched with half_period_i.
- sync_short_pause_o  output  1  one-cycle pulse.
- sync_long_pause_o  output  1  one-cycle pulse.
- pre_short_pause_o  output  1  one-cycle pulse.
- pre_long_pause_o  output  1  one-cycle pulse.
- pause_count_o  output  CYCLE_BITWIDTH  current pause length, in output periods.
- paused_o  output  1  high while in state PAUSED.
- clk_lock_o  output  1  output clock is stable and running.
- clk_o  output  1  generated clock, driven from a register.

Behaviour:
- Reset (arst_n low, asynchronous): state IDLE; phase counter 0; pause counter 0.
- Output values during reset: clk_o=1, clk_lock_o=0, paused_o=0, all pulses 0, pause_count_o=0.
- All transitions below occur only on clk edges with clk_en=1.
- States:
  - IDLE: clk_o=1. On generation_enable_i=1, latch half_period_i and preemptive_cycle_count_i, then go to START.
  - START: one cycle; phase counter cleared. Next state RUN. clk_lock_o rises on the following cycle, i.e. 2 enabled cycles after enable was sampled.
  - RUN: phase counter counts 0..H-1, where H is the latched half-period. At H-1 it wraps to 0 and clk_o toggles. The first toggle after START is a falling edge. Output period is 2*H enabled cycles.
  - PAUSE_PEND: entered from RUN when pause_enable_i=1. Runs on until the next rising toggle. At that toggle clk_o goes 1, state becomes PAUSED and the pause counter clears to 0.
  - PAUSED: clk_o held 1; the phase counter keeps running. Each virtual falling boundary increments the pause counter, saturating at LONG_LENGTH.
  - Leaving PAUSED: on pause_enable_i=0, wait for the next virtual falling boundary. At that boundary clk_o falls, state goes to RUN and the pause counter clears.
- Pulses (one enabled cycle each, asserted in the cycle pause_count_o reaches the value):
  - sync_short_pause_o: when pause_count_o becomes SHORT_LENGTH.
  - sync_long_pause_o: when pause_count_o becomes LONG_LENGTH.
  - Preemptive pulses fire at count == threshold - P, where P is the latched preemptive count. If P >= threshold, the preemptive pulse fires on the cycle PAUSED is entered.
  - Each pulse fires at most once per pause.
- Simultaneous events:
  - pause_enable_i deasserted while in PAUSE_PEND: cancel, return to RUN, no park.
  - pause_enable_i re-asserted while waiting to leave PAUSED: stay PAUSED; counter is not cleared.
- generation_enable_i=0 in any state has priority over everything else. Next enabled cycle: IDLE, clk_o=1, clk_lock_o=0, paused_o=0, counters cleared. A pulse due in that same cycle is suppressed.
- half_period_i changes while running are ignored until the next IDLE->START.
- The phase counter is DIV_BITWIDTH wide and never exceeds H-1.
- The pause-counter compare uses unsigned CYCLE_BITWIDTH arithmetic; no wrap is possible because of saturation.

Decomposition:
- Shared package io_clk_p holds CYCLE_BITWIDTH, DIV_BITWIDTH, SHORT_LENGTH/LONG_LENGTH defaults and the state enum typedef gen_state_t.
- One sub-module, clock_gen_pause_tracker: pause counter with saturation, the four threshold comparators and the once-per-pause pulse flags.
- The FSM and phase counter stay in the top module.

Test Plan:
- Enable with half_period_i=3, clk_en=1 -> clk_lock_o high 2 cycles after enable; clk_o period is 6 cycles with 50% duty; first transition is falling.
- half_period_i=0 -> behaves as H=1, clk_o toggles every cycle; clk_en toggling 1/0 -> period doubles in system cycles.
- H=4, pause asserted mid low phase -> clk_o rises at the scheduled edge and stays high. With P=2: pre_short at count 2, sync_short at 4, pre_long at 14, sync_long at 16; pause_count_o saturates at 16.
- Deassert pause at count 5 -> clk_o falls at the next 8-cycle virtual boundary; pause_count_o returns to 0; no long pulses.
- P=20 (greater than LONG_LENGTH) -> both preemptive pulses fire on the PAUSED entry cycle; sync pulses unchanged.
- Assert arst_n=0 mid-PAUSED, and separately drop generation_enable_i mid-RUN -> immediate (async) or next-cycle return to clk_o=1, lock 0, paused 0, no stray pulses.
